// File: rtl/ic232_pkg.sv
// Shared types and select-code constants for steering an ic232 latch pair.
package ic232_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_DRIVE = 2'd2
  } state_t;

  // {A2,A1,A0} codes understood by the ic232
  localparam logic [2:0] CODE_SET0 = 3'b000;
  localparam logic [2:0] CODE_CLR0 = 3'b010;
  localparam logic [2:0] CODE_TGL  = 3'b100;
  localparam logic [2:0] CODE_Q1T  = 3'b110;

endpackage

// File: rtl/ic232_step_code.sv
// Maps live state q, target t and the drive flag to the ic232 select code.
module ic232_step_code
  import ic232_pkg::*;
(
  input  logic [1:0] i_q,
  input  logic [1:0] i_t,
  input  logic       i_drive,
  output logic [2:0] o_code
);

  always_comb begin
    // Hold: re-assert the current Q0 so nothing moves
    o_code = i_q[0] ? CODE_SET0 : CODE_CLR0;
    if (i_drive) begin
      if (i_t[1] == i_q[1]) begin
        o_code = i_t[0] ? CODE_SET0 : CODE_CLR0;
      end else begin
        o_code = (i_t[0] && !i_q[0]) ? CODE_TGL : CODE_Q1T;
      end
    end
  end

endmodule

// File: rtl/ic232_steer.sv
// Closed-loop steering controller: drives an ic232 toward a requested {Q1,Q0}
// one step at a time, reporting done, or err once MAX_STEPS is exhausted.
module ic232_steer
  import ic232_pkg::*;
#(
  parameter int MAX_STEPS = 2,
  parameter int STEP_W    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic [1:0]        req_state,
  output logic              req_ready,
  input  logic              Q0_fb,
  input  logic              Q1_fb,
  output logic              A0,
  output logic              A1,
  output logic              A2,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [STEP_W-1:0] steps
);

  localparam logic [STEP_W-1:0] STEPS_MAX = STEP_W'(MAX_STEPS);
  localparam logic [STEP_W-1:0] STEP_ONE  = STEP_W'(1);

  state_t            r_state;
  logic [1:0]        r_target;
  logic [STEP_W-1:0] r_steps;
  logic              r_done;
  logic              r_err;

  logic [1:0] w_q;
  logic [2:0] w_code;
  logic       w_drive;

  assign w_q     = {Q1_fb, Q0_fb};
  assign w_drive = (r_state == ST_DRIVE);

  ic232_step_code u_code (
    .i_q    (w_q),
    .i_t    (r_target),
    .i_drive(w_drive),
    .o_code (w_code)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_target <= 2'b00;
      r_steps  <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_target <= req_state;
            r_steps  <= '0;
            r_err    <= 1'b0;
            r_state  <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (w_q == r_target) begin
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
          end else if (r_steps == STEPS_MAX) begin
            r_err   <= 1'b1;
            r_state <= ST_IDLE;
          end else begin
            r_state <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          // Saturate rather than wrap, even though CHECK normally guards this
          if (r_steps != STEPS_MAX) begin
            r_steps <= r_steps + STEP_ONE;
          end
          r_state <= ST_CHECK;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready    = (r_state == ST_IDLE);
  assign busy         = !req_ready;
  assign done         = r_done;
  assign err          = r_err;
  assign steps        = r_steps;
  assign {A2, A1, A0} = w_code;

endmodule

// File: tb/tb_ic232_steer.sv
// Closed-loop bench: a behavioural ic232 sits on the A outputs and feeds Q back.
module tb_ic232_steer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic [1:0] req_state;
  logic       req_ready;
  logic       Q0_fb, Q1_fb;
  logic       A0, A1, A2;
  logic       busy, done, err;
  logic [1:0] steps;

  logic [1:0] plant_q;
  logic       stuck;
  logic [2:0] a_code;

  always #5 clk = ~clk;

  ic232_steer #(.MAX_STEPS(2), .STEP_W(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_state(req_state),
    .req_ready(req_ready),
    .Q0_fb    (Q0_fb),
    .Q1_fb    (Q1_fb),
    .A0       (A0),
    .A1       (A1),
    .A2       (A2),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .steps    (steps)
  );

  assign a_code = {A2, A1, A0};
  assign Q0_fb  = stuck ? 1'b0 : plant_q[0];
  assign Q1_fb  = stuck ? 1'b0 : plant_q[1];

  // ic232 model: 000 sets Q0, 010 clears Q0, 100 toggles both, 110 toggles Q1 and clears Q0
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) plant_q <= 2'b00;
    else begin
      case (a_code)
        3'b000:  plant_q[0] <= 1'b1;
        3'b010:  plant_q[0] <= 1'b0;
        3'b100:  plant_q <= ~plant_q;
        3'b110:  plant_q <= {~plant_q[1], 1'b0};
        default: plant_q <= plant_q;
      endcase
    end
  end

  int n_chk  = 0;
  int n_pass = 0;
  logic [2:0] seen [0:31];
  int lat;
  bit got_done, got_err;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Samples at each negedge after the accept edge; sample i follows edge i
  task automatic monitor();
    lat = -1; got_done = 0; got_err = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      seen[i] = a_code;
      if (done) begin got_done = 1; lat = i; break; end
      if (err)  begin got_err  = 1; lat = i; break; end
    end
  endtask

  task automatic request(input logic [1:0] tgt);
    int k;
    @(negedge clk);
    req_state = tgt;
    req_valid = 1'b1;
    k = 0;
    do begin
      @(posedge clk); #1; k++;
    end while (!busy && k < 10);
    req_valid = 1'b0;
    if (!busy) chk("accept_timeout", 0, 1);
    monitor();
  endtask

  // Reference: steps needed to reach t from q under the ic232 select rules
  function automatic int ref_steps(input logic [1:0] q, input logic [1:0] t);
    if (q == t) return 0;
    if (q[1] == t[1]) return 1;
    if (q[0] && t[0]) return 2;
    return 1;
  endfunction

  typedef struct {
    logic [1:0] tgt;
    logic [1:0] start;
    int         n_steps;
    int         lat;
    logic [2:0] c0;
    logic [2:0] c1;
  } vec_t;

  vec_t tbl [9];
  logic [1:0] model_q;
  logic [1:0] tgt;
  int s;
  bit bad;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{2'b01, 2'b00, 1, 3, 3'b000, 3'b000};
    tbl[1] = '{2'b11, 2'b01, 2, 5, 3'b110, 3'b000};
    tbl[2] = '{2'b00, 2'b11, 1, 3, 3'b110, 3'b000};
    tbl[3] = '{2'b10, 2'b00, 1, 3, 3'b110, 3'b000};
    tbl[4] = '{2'b10, 2'b10, 0, 1, 3'b000, 3'b000};
    tbl[5] = '{2'b01, 2'b10, 1, 3, 3'b100, 3'b000};
    tbl[6] = '{2'b10, 2'b01, 1, 3, 3'b110, 3'b000};
    tbl[7] = '{2'b11, 2'b10, 1, 3, 3'b000, 3'b000};
    tbl[8] = '{2'b01, 2'b11, 2, 5, 3'b110, 3'b000};

    rst_n = 1'b0; req_valid = 1'b0; req_state = 2'b00; stuck = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_steps", steps, 0);
    chk("rst_hold_code", a_code, 3'b010);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      chk($sformatf("v%0d_start_q", i), plant_q, tbl[i].start);
      request(tbl[i].tgt);
      chk($sformatf("v%0d_done", i), got_done, 1);
      chk($sformatf("v%0d_latency", i), lat, tbl[i].lat);
      chk($sformatf("v%0d_steps", i), steps, tbl[i].n_steps);
      chk($sformatf("v%0d_err", i), err, 0);
      chk($sformatf("v%0d_final_q", i), plant_q, tbl[i].tgt);
      chk($sformatf("v%0d_hold_code", i), seen[0], {1'b0, ~tbl[i].start[0], 1'b0});
      if (tbl[i].n_steps >= 1) chk($sformatf("v%0d_drive_code0", i), seen[1], tbl[i].c0);
      if (tbl[i].n_steps >= 2) chk($sformatf("v%0d_drive_code1", i), seen[3], tbl[i].c1);
      @(negedge clk);
      chk($sformatf("v%0d_done_pulse", i), done, 0);
      $display("vec %0d: tgt=%b steps=%0d lat=%0d", i, tbl[i].tgt, steps, lat);
    end

    // Stuck feedback: two drive steps, then err with no done
    stuck = 1'b1;
    request(2'b11);
    chk("stuck_err", got_err, 1);
    chk("stuck_no_done", got_done, 0);
    chk("stuck_latency", lat, 5);
    chk("stuck_code0", seen[1], 3'b100);
    chk("stuck_code1", seen[3], 3'b100);
    chk("stuck_steps", steps, 2);
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (done || !err) bad = 1;
    end
    chk("stuck_err_sticky", bad, 0);
    $display("stuck: err=%b steps=%0d", err, steps);
    stuck = 1'b0;
    model_q = plant_q;

    // Next accept clears err
    tgt = 2'b10;
    @(negedge clk);
    req_state = tgt; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("accept_clears_err", err, 0);
    chk("accept_busy", busy, 1);
    monitor();
    chk("after_err_done", got_done, 1);
    chk("after_err_latency", lat, 1 + 2 * ref_steps(model_q, tgt));
    model_q = tgt;
    $display("recover: tgt=%b steps=%0d lat=%0d", tgt, steps, lat);

    // Reset during DRIVE
    tgt = model_q ^ 2'b10;
    @(negedge clk);
    req_state = tgt; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", req_ready, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_err", err, 0);
    chk("midrst_steps", steps, 0);
    chk("midrst_hold_code", a_code, 3'b010);
    req_state = 2'b01; req_valid = 1'b1;
    @(posedge clk); #1;
    chk("no_accept_in_reset", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("accept_after_reset", busy, 1);
    req_valid = 1'b0;
    monitor();
    chk("postrst_done", got_done, 1);
    chk("postrst_latency", lat, 3);
    chk("postrst_steps", steps, 1);
    chk("postrst_final_q", plant_q, 2'b01);
    model_q = 2'b01;
    $display("reset-mid-drive: recovered steps=%0d lat=%0d", steps, lat);

    // Randomised requests against the reference model
    for (int i = 0; i < 40; i++) begin
      tgt = 2'($urandom_range(0, 3));
      s = ref_steps(model_q, tgt);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      request(tgt);
      chk($sformatf("r%0d_done", i), got_done, 1);
      chk($sformatf("r%0d_latency", i), lat, 1 + 2 * s);
      chk($sformatf("r%0d_steps", i), steps, s);
      chk($sformatf("r%0d_final_q", i), plant_q, tgt);
      $display("rand %0d: %b->%b steps=%0d lat=%0d", i, model_q, tgt, steps, lat);
      model_q = tgt;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ic232_steer.md
IC232_STEER -- requirements
Module: ic232_steer

Interface
REQ-001 Parameter MAX_STEPS, default 2: drive steps allowed per request before error.
REQ-002 Parameter STEP_W, default 2: width of step counter; must hold MAX_STEPS.
REQ-003 clk  input  1  single clock; all state changes on posedge clk.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 req_valid  input  1  target request present.
REQ-006 req_state  input  2  target {Q1,Q0}.
REQ-007 req_ready  output  1  block can accept a request.
REQ-008 Q0_fb, Q1_fb  input  1 each  live state fed back from the ic232 instance being steered.
REQ-009 A0, A1, A2  output  1 each  select inputs driven into the ic232 instance.
REQ-010 busy  output  1  request in progress.
REQ-011 done  output  1  one-cycle pulse: target reached.
REQ-012 err  output  1  target not reached within MAX_STEPS; sticky until next accept.
REQ-013 steps  output  STEP_W  drive steps used by the last or current request.

Function
REQ-014 FSM states: IDLE, CHECK, DRIVE.
REQ-015 req_ready = 1 only in IDLE; busy = 1 in CHECK and DRIVE.
REQ-016 Accept on posedge with req_valid=1 and req_ready=1: latch req_state into target, clear steps, clear err, go to CHECK.
REQ-017 Requests presented while busy are not accepted and are not lost; req_valid must be held by the source.
REQ-018 Hold code, used in IDLE and CHECK: {A2,A1,A0} = {0, ~Q0_fb, 0} (000 if Q0_fb=1, 010 if Q0_fb=0).
REQ-019 Step code, used in DRIVE, with q={Q1_fb,Q0_fb} and t=target:
- t1==q1: 000 if t0=1, else 010.
- t1!=q1: 100 if t0=1 and q0=0, else 110.
REQ-020 A outputs are combinational from the FSM state, target and feedback; they are not registered.
REQ-021 CHECK behaviour:
- q==t: go to IDLE; done=1 the following cycle.
- q!=t and steps==MAX_STEPS: go to IDLE; err=1 from the following cycle.
- otherwise: go to DRIVE.
REQ-022 DRIVE lasts exactly one cycle: steps increments and the state returns to CHECK.
REQ-023 done is registered and high for exactly one cycle per successful request; done and err are never both asserted for the same request.
REQ-024 Latency from accept edge to done:
- 1 cycle when already at target.
- 3 cycles for one drive step.
- 5 cycles for two drive steps.
REQ-025 Case t1!=q1 with q0=t0=1 takes two steps by construction: 110, then 000.
REQ-026 steps saturates at MAX_STEPS and never wraps.

Reset
REQ-027 On rst_n low, at any time including mid-DRIVE:
- state = IDLE, target = 00, steps = 0, done = 0, err = 0.
- req_ready = 1, busy = 0.
- A outputs revert immediately to the hold code.
REQ-028 No request is accepted while rst_n is low; the first accept is possible on the first posedge after deassertion.

Structure
REQ-029 Shared package ic232_pkg holds:
- the FSM state enumeration;
- 3-bit code constants CODE_SET0=000, CODE_CLR0=010, CODE_TGL=100, CODE_Q1T=110.
REQ-030 One sub-module, ic232_step_code (combinational): takes q, t and a drive flag and returns {A2,A1,A0}. It implements both the hold and step tables.
REQ-031 The FSM, target register, step counter, done and err live in ic232_steer.

Verification
REQ-032 The bench closes the loop: ic232 outputs Q0 and Q1 drive Q0_fb and Q1_fb, and A0..A2 drive the ic232 inputs.
REQ-033 Scenario 1: after reset Q=00, request 01 -> A=000 in DRIVE, Q=01, done 3 cycles after accept, steps=1.
REQ-034 Scenario 2: Q=01, request 11 -> A=110 then Q=10, then A=000 then Q=11; done 5 cycles after accept; steps=2.
REQ-035 Scenario 3: Q=11, request 00 -> A=110, Q=00, steps=1, done.
REQ-036 Scenario 4: Q=10, request 10 -> done 1 cycle after accept, steps=0, no DRIVE cycle.
REQ-037 Scenario 5: feedback forced stuck at 00, request 11 -> two DRIVE cycles, err=1, done never asserted, steps=2.
REQ-038 Scenario 6: rst_n pulsed low during DRIVE -> IDLE immediately, req_ready=1, done=0, err=0; a new request then completes normally.
